devil_snoop_responder: RTL and testbench



---
 rtl/devil_snoop_responder_if.sv | 26 ++
 rtl/devil_snoop_responder.sv | 182 ++++++++++++++++++
 tb/tb_devil_snoop_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/devil_snoop_responder_if.sv
// ACE snoop channel bundle: AC request, CR response and CD data between interconnect and responder.
interface devil_snoop_responder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 44
);
  logic                  acvalid;
  logic                  acready;
  logic [3:0]            acsnoop;
  logic [ADDR_WIDTH-1:0] acaddr;
  logic                  crvalid;
  logic                  crready;
  logic [4:0]            crresp;
  logic                  cdvalid;
  logic                  cdready;
  logic [DATA_WIDTH-1:0] cddata;
  logic                  cdlast;

  modport master (
    output acvalid, acsnoop, acaddr, crready, cdready,
    input  acready, crvalid, crresp, cdvalid, cddata, cdlast
  );
  modport slave (
    input  acvalid, acsnoop, acaddr, crready, cdready,
    output acready, crvalid, crresp, cdvalid, cddata, cdlast
  );
endinterface

// File: rtl/devil_snoop_responder.sv
// ACE snoop responder: answers every snoop, manipulating filtered ones (CRRESP, CD line data, delay).
// Optional DEVIL_DELAY_ABORT_EN: dropping i_enable during DELAY ends the delay on the next edge.
module devil_snoop_responder #(
  parameter int C_ACE_DATA_WIDTH = 128,
  parameter int C_ACE_ADDR_WIDTH = 44,
  parameter int NUM_REGIONS      = 4,
  parameter int DELAY_WIDTH      = 32,
  parameter int CACHE_LINE_BYTES = 64
) (
  input  logic                                  ace_aclk,
  input  logic                                  ace_aresetn,
  devil_snoop_responder_if.slave                ace,
  input  logic                                  i_enable,
  input  logic [1:0]                            i_mode,
  input  logic [15:0]                           i_shot_count,
  input  logic [4:0]                            i_crresp,
  input  logic [C_ACE_DATA_WIDTH-1:0]           i_fill_pattern,
  input  logic                                  i_acsnoop_flt_en,
  input  logic [3:0]                            i_acsnoop_match,
  input  logic [NUM_REGIONS-1:0]                i_region_en,
  input  logic [NUM_REGIONS*C_ACE_ADDR_WIDTH-1:0] i_region_base,
  input  logic [NUM_REGIONS*C_ACE_ADDR_WIDTH-1:0] i_region_size,
  input  logic [DELAY_WIDTH-1:0]                i_delay,
  input  logic [1:0]                            i_delay_sel,
  input  logic                                  i_clear_status,
  output logic                                  o_done,
  output logic [31:0]                           o_hit_count,
  output logic [NUM_REGIONS-1:0]                o_region_hit,
  output logic [3:0]                            o_state
);
  localparam int AW    = C_ACE_ADDR_WIDTH;
  localparam int BEATS = CACHE_LINE_BYTES * 8 / C_ACE_DATA_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [BW-1:0] PEN_BEAT  = BW'((BEATS > 1) ? BEATS - 2 : 0);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_MATCH = 4'd1,
    S_DELAY = 4'd2,
    S_CR    = 4'd3,
    S_CD    = 4'd4,
    S_DONE  = 4'd5
  } state_t;

  state_t                  state, state_n;
  logic [3:0]              snoop_q;
  logic [AW-1:0]           addr_q;
  logic                    manip_q;
  logic                    data_q;
  logic [4:0]              crresp_q;
  logic [C_ACE_DATA_WIDTH-1:0] fill_q;
  logic [BW-1:0]           beat_q;
  logic [DELAY_WIDTH-1:0]  dly_cnt;
  logic                    dly_to_cd;
  logic [15:0]             shot_cnt;

  logic [NUM_REGIONS-1:0]  region_hit;
  logic                    mode_ok, type_ok, addr_ok, manip_now, quota_zero;
  logic                    dly_nz, dly_end, first_dly, last_dly;

  // Region limit is formed one bit wider so base+size past the top of the address space cannot wrap.
  always_comb begin
    region_hit = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      region_hit[k] = i_region_en[k]
                   && (addr_q >= i_region_base[k*AW +: AW])
                   && ({1'b0, addr_q} < ({1'b0, i_region_base[k*AW +: AW]}
                                       + {1'b0, i_region_size[k*AW +: AW]}));
    end
  end

  assign quota_zero = (i_mode == 2'd3) && (i_shot_count == 16'd0);

  always_comb begin
    mode_ok = 1'b0;
    case (i_mode)
      2'd1:    mode_ok = !o_done;
      2'd2:    mode_ok = 1'b1;
      2'd3:    mode_ok = !o_done && !quota_zero;
      default: mode_ok = 1'b0;
    endcase
  end

  assign type_ok   = !i_acsnoop_flt_en || (snoop_q == i_acsnoop_match);
  assign addr_ok   = !(|i_region_en) || (|region_hit);
  assign manip_now = i_enable && mode_ok && type_ok && addr_ok;

  assign dly_nz    = (i_delay != '0);
  // With a single-beat line the "before last beat" point coincides with the first beat.
  assign first_dly = dly_nz && ((i_delay_sel == 2'd2) || ((i_delay_sel == 2'd3) && (BEATS == 1)));
  assign last_dly  = dly_nz && (i_delay_sel == 2'd3) && (BEATS > 1);

`ifdef DEVIL_DELAY_ABORT_EN
  assign dly_end = (dly_cnt == i_delay - DELAY_WIDTH'(1)) || !i_enable;
`else
  assign dly_end = (dly_cnt == i_delay - DELAY_WIDTH'(1));
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (ace.acvalid) state_n = S_MATCH;
      S_MATCH: state_n = (manip_now && (i_delay_sel == 2'd1) && dly_nz) ? S_DELAY : S_CR;
      S_DELAY: if (dly_end) state_n = dly_to_cd ? S_CD : S_CR;
      S_CR: begin
        if (ace.crready) begin
          if (!data_q)        state_n = S_DONE;
          else if (first_dly) state_n = S_DELAY;
          else                state_n = S_CD;
        end
      end
      S_CD: begin
        if (ace.cdready) begin
          if (beat_q == LAST_BEAT)                 state_n = S_DONE;
          else if (last_dly && beat_q == PEN_BEAT) state_n = S_DELAY;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state        <= S_IDLE;
      snoop_q      <= '0;
      addr_q       <= '0;
      manip_q      <= 1'b0;
      data_q       <= 1'b0;
      crresp_q     <= '0;
      fill_q       <= '0;
      beat_q       <= '0;
      dly_cnt      <= '0;
      dly_to_cd    <= 1'b0;
      shot_cnt     <= '0;
      o_done       <= 1'b0;
      o_hit_count  <= '0;
      o_region_hit <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && ace.acvalid) begin
        snoop_q <= ace.acsnoop;
        addr_q  <= ace.acaddr;
      end
      if (state == S_MATCH) begin
        o_region_hit <= region_hit;
        manip_q      <= manip_now;
        data_q       <= manip_now && i_crresp[0];
        crresp_q     <= manip_now ? i_crresp : 5'd0;
        fill_q       <= i_fill_pattern;
        beat_q       <= '0;
      end
      if (state == S_CD && ace.cdready) beat_q <= beat_q + BW'(1);
      if (state_n == S_DELAY && state != S_DELAY) dly_to_cd <= (state != S_MATCH);
      dly_cnt <= (state == S_DELAY && state_n == S_DELAY) ? dly_cnt + DELAY_WIDTH'(1) : '0;

      // Clear takes priority over the completion bookkeeping of the same cycle.
      if (i_clear_status) begin
        o_done      <= 1'b0;
        shot_cnt    <= '0;
        o_hit_count <= '0;
      end else begin
        if (state == S_MATCH && quota_zero) o_done <= 1'b1;
        if (state == S_DONE && manip_q) begin
          if (o_hit_count != 32'hFFFF_FFFF) o_hit_count <= o_hit_count + 32'd1;
          shot_cnt <= shot_cnt + 16'd1;
          if ((i_mode == 2'd1) || ((i_mode == 2'd3) && (shot_cnt + 16'd1 == i_shot_count)))
            o_done <= 1'b1;
        end
      end
    end
  end

  assign ace.acready = (state == S_IDLE);
  assign ace.crvalid = (state == S_CR);
  assign ace.crresp  = crresp_q;
  assign ace.cdvalid = (state == S_CD);
  assign ace.cddata  = (state == S_CD) ? fill_q : '0;
  assign ace.cdlast  = (state == S_CD) && (beat_q == LAST_BEAT);
  assign o_state     = state;
endmodule

// File: tb/tb_devil_snoop_responder.sv
// Randomized bench for devil_snoop_responder against a transaction-level reply model.
module tb_devil_snoop_responder;
  localparam int DW = 128, AW = 44, NR = 4, BEATS = 4;

  logic ace_aclk = 1'b0, ace_aresetn = 1'b0;
  always #5 ace_aclk = ~ace_aclk;

  devil_snoop_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ace();

  logic          i_enable, i_acsnoop_flt_en, i_clear_status;
  logic [1:0]    i_mode, i_delay_sel;
  logic [15:0]   i_shot_count;
  logic [4:0]    i_crresp;
  logic [DW-1:0] i_fill_pattern;
  logic [3:0]    i_acsnoop_match;
  logic [NR-1:0] i_region_en;
  logic [NR*AW-1:0] i_region_base, i_region_size;
  logic [31:0]   i_delay;
  logic          o_done;
  logic [31:0]   o_hit_count;
  logic [NR-1:0] o_region_hit;
  logic [3:0]    o_state;

  devil_snoop_responder dut (
    .ace_aclk(ace_aclk), .ace_aresetn(ace_aresetn), .ace(ace),
    .i_enable(i_enable), .i_mode(i_mode), .i_shot_count(i_shot_count), .i_crresp(i_crresp),
    .i_fill_pattern(i_fill_pattern), .i_acsnoop_flt_en(i_acsnoop_flt_en),
    .i_acsnoop_match(i_acsnoop_match), .i_region_en(i_region_en),
    .i_region_base(i_region_base), .i_region_size(i_region_size), .i_delay(i_delay),
    .i_delay_sel(i_delay_sel), .i_clear_status(i_clear_status), .o_done(o_done),
    .o_hit_count(o_hit_count), .o_region_hit(o_region_hit), .o_state(o_state)
  );

  int n_pass = 0, n_total = 0;
  bit    m_done = 0;
  int    m_shots = 0;
  longint m_hits = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_region(input int k, input logic en, input logic [AW-1:0] base, input logic [AW-1:0] size);
    i_region_en[k] = en;
    i_region_base[k*AW +: AW] = base;
    i_region_size[k*AW +: AW] = size;
  endtask

  task automatic pulse_clear();
    i_clear_status = 1'b1;
    @(negedge ace_aclk);
    i_clear_status = 1'b0;
    m_done = 0; m_shots = 0; m_hits = 0;
  endtask

  // Reply decision from the configuration rules, using unbounded integer address arithmetic.
  function automatic bit predict(input logic [AW-1:0] addr, input logic [3:0] snp, output logic [NR-1:0] hits);
    bit allow, type_ok, addr_ok;
    longint a, b, s;
    a = longint'(addr);
    for (int k = 0; k < NR; k++) begin
      b = longint'(i_region_base[k*AW +: AW]);
      s = longint'(i_region_size[k*AW +: AW]);
      hits[k] = i_region_en[k] && (a >= b) && (a < b + s);
    end
    case (i_mode)
      2'd1:    allow = !m_done;
      2'd2:    allow = 1;
      2'd3:    allow = !m_done && (i_shot_count != 0);
      default: allow = 0;
    endcase
    type_ok = !i_acsnoop_flt_en || (snp == i_acsnoop_match);
    addr_ok = (i_region_en == 0) || (hits != 0);
    return i_enable && allow && type_ok && addr_ok;
  endfunction

  // One snoop: issue AC, serve CR/CD with the given ready behaviour, check the whole reply.
  task automatic run_snoop(input logic [AW-1:0] addr, input logic [3:0] snp, input int cr_stall,
                           input bit cd_rand, output int t_cr, output int t_first, output int t_gap,
                           output logic [4:0] rsp, output int nb);
    logic [NR-1:0] ehits;
    bit manip, prev_cr_wait = 0, prev_cd_wait = 0;
    logic [4:0] eresp, prev_resp = '0;
    logic [DW-1:0] prev_data = '0;
    int ebeats, n, cr_seen = 0, ncr = 0, d;
    int beat_t[8];
    manip  = predict(addr, snp, ehits);
    eresp  = manip ? i_crresp : 5'd0;
    ebeats = (manip && i_crresp[0]) ? BEATS : 0;
    d      = int'(i_delay);
    if (i_mode == 2'd3 && i_shot_count == 0) m_done = 1;
    t_cr = -1; t_first = -1; t_gap = -1; rsp = 'x; nb = 0;

    ace.acvalid = 1'b1; ace.acaddr = addr; ace.acsnoop = snp;
    n = 0;
    while (!ace.acready && n < 100) begin @(negedge ace_aclk); n++; end
    @(negedge ace_aclk);
    ace.acvalid = 1'b0;
    n = 1;
    while (!ace.acready && n < 2000) begin
      ace.crready = (cr_seen >= cr_stall);
      ace.cdready = cd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ace.crvalid) begin
        if (prev_cr_wait) check("cr_stable", ace.crresp, prev_resp);
        cr_seen++;
        if (ace.crready) begin rsp = ace.crresp; t_cr = n; ncr++; end
      end
      prev_cr_wait = ace.crvalid && !ace.crready;
      prev_resp    = ace.crresp;
      if (ace.cdvalid) begin
        if (prev_cd_wait) check("cd_stable", ace.cddata, prev_data);
        if (ace.cdready) begin
          check("cd_data", ace.cddata, i_fill_pattern);
          check("cd_last", ace.cdlast, nb == BEATS - 1);
          if (ncr == 0) check("cd_before_cr", 0, 1);
          if (nb < 8) beat_t[nb] = n;
          nb++;
        end
      end
      prev_cd_wait = ace.cdvalid && !ace.cdready;
      prev_data    = ace.cddata;
      @(negedge ace_aclk);
      n++;
    end
    if (n >= 2000) check("reply_timeout", 0, 1);
    check("cr_handshakes", ncr, 1);
    check("crresp", rsp, eresp);
    check("cd_beats", nb, ebeats);
    check("region_hit", o_region_hit, ehits);
    if (manip) begin
      if (m_hits < 64'hFFFF_FFFF) m_hits++;
      m_shots++;
      if (i_mode == 2'd1 || (i_mode == 2'd3 && m_shots == int'(i_shot_count))) m_done = 1;
    end
    check("hit_count", o_hit_count, m_hits[31:0]);
    check("done", o_done, m_done);
    if (nb >= 1) t_first = beat_t[0];
    if (nb >= 4) t_gap = beat_t[3] - beat_t[2];
    if (cr_stall == 0 && !cd_rand) begin
      check("cr_latency", t_cr, 2 + ((manip && i_delay_sel == 2'd1) ? d : 0));
      if (ebeats == BEATS && nb == BEATS) begin
        check("first_beat_latency", t_first, t_cr + 1 + ((i_delay_sel == 2'd2) ? d : 0));
        check("last_beat_gap", t_gap, 1 + ((i_delay_sel == 2'd3) ? d : 0));
      end
    end
  endtask

  initial begin
    int tcr, tfirst, tgap, nb, k, n;
    logic [4:0] rsp;
    logic [AW-1:0] a;
    ace.acvalid = 0; ace.acsnoop = 0; ace.acaddr = 0; ace.crready = 1; ace.cdready = 1;
    i_enable = 1; i_mode = 2; i_shot_count = 0; i_crresp = 0; i_fill_pattern = 0;
    i_acsnoop_flt_en = 0; i_acsnoop_match = 0; i_region_en = 0; i_region_base = 0;
    i_region_size = 0; i_delay = 0; i_delay_sel = 0; i_clear_status = 0;
    repeat (3) @(negedge ace_aclk);
    check("rst_acready", ace.acready, 1);
    check("rst_crvalid", ace.crvalid, 0);
    check("rst_cdvalid", ace.cdvalid, 0);
    check("rst_crresp", ace.crresp, 0);
    check("rst_outputs", {ace.cdlast, ace.cddata, o_done, o_hit_count, o_region_hit, o_state}, 0);
    ace_aresetn = 1;
    @(negedge ace_aclk);

    // Continuous mode, data transfer, full-speed handshakes.
    i_crresp = 5'b00001; i_fill_pattern = {16{8'hA5}};
    run_snoop(44'h2000, 4'h1, 0, 0, tcr, tfirst, tgap, rsp, nb);
    check("t1_cr_lat", tcr, 2);
    check("t1_beats", nb, 4);
    check("t1_first", tfirst, 3);
    check("t1_hits", o_hit_count, 1);

    // One-shot: only the first snoop after a clear is manipulated.
    i_mode = 1;
    run_snoop(44'h3000, 4'h2, 0, 0, tcr, tfirst, tgap, rsp, nb); check("t2_rsp0", rsp, 1);
    run_snoop(44'h3040, 4'h2, 0, 0, tcr, tfirst, tgap, rsp, nb); check("t2_rsp1", rsp, 0);
    run_snoop(44'h3080, 4'h2, 0, 0, tcr, tfirst, tgap, rsp, nb); check("t2_nb2", nb, 0);
    check("t2_done", o_done, 1);
    pulse_clear();
    check("t2_clr_done", o_done, 0);
    run_snoop(44'h30C0, 4'h2, 0, 0, tcr, tfirst, tgap, rsp, nb); check("t2_rsp3", rsp, 1);

    // N-shot with a single address window.
    pulse_clear();
    i_mode = 3; i_shot_count = 2;
    set_region(0, 1'b1, 44'h1000, 44'h100);
    run_snoop(44'h10FF, 4'h0, 0, 0, tcr, tfirst, tgap, rsp, nb);
    check("t3_hit_a", o_region_hit, 4'b0001); check("t3_rsp_a", rsp, 1);
    run_snoop(44'h1100, 4'h0, 0, 0, tcr, tfirst, tgap, rsp, nb);
    check("t3_miss", o_region_hit, 4'b0000); check("t3_rsp_b", rsp, 0);
    run_snoop(44'h1000, 4'h0, 0, 0, tcr, tfirst, tgap, rsp, nb);
    check("t3_hit_c", o_region_hit, 4'b0001); check("t3_done", o_done, 1);

    // Delay placement.
    pulse_clear();
    i_mode = 2; i_region_en = 0; i_delay = 10; i_delay_sel = 1;
    run_snoop(44'h5000, 4'h3, 0, 0, tcr, tfirst, tgap, rsp, nb); check("t4_cr_dly", tcr, 12);
    i_delay_sel = 3;
    run_snoop(44'h5040, 4'h3, 0, 0, tcr, tfirst, tgap, rsp, nb); check("t4_gap", tgap, 11);

    // Backpressure on both channels.
    i_delay_sel = 0; i_fill_pattern = {4{32'h1234_5678}};
    run_snoop(44'h6000, 4'h4, 7, 1, tcr, tfirst, tgap, rsp, nb); check("t5_beats", nb, 4);

    // Randomized configurations around region edges, including a window at the top of the space.
    set_region(0, 1'b0, 44'h1_0000, 44'h100);
    set_region(1, 1'b0, 44'h2_0000, 44'h200);
    set_region(2, 1'b0, 44'h3_0000, 44'h0);
    set_region(3, 1'b0, 44'hFFF_FFFF_FF00, 44'h200);
    for (int it = 0; it < 150; it++) begin
      i_enable = ($urandom_range(0, 9) != 0);
      i_mode = 2'($urandom_range(0, 3));
      i_shot_count = 16'($urandom_range(0, 3));
      i_crresp = 5'($urandom);
      i_fill_pattern = {$urandom, $urandom, $urandom, $urandom};
      i_acsnoop_flt_en = ($urandom_range(0, 3) == 0);
      i_acsnoop_match = 4'($urandom_range(0, 3));
      i_region_en = 4'($urandom);
      for (int r = 0; r < 3; r++)
        i_region_size[r*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 32'h200));
      i_delay = $urandom_range(0, 4);
      i_delay_sel = 2'($urandom_range(0, 3));
      k = $urandom_range(0, NR - 1);
      a = i_region_base[k*AW +: AW] + AW'($urandom_range(0, 32'h240)) - AW'(32'h20);
      if ($urandom_range(0, 9) == 0) pulse_clear();
      run_snoop(a, 4'($urandom_range(0, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                tcr, tfirst, tgap, rsp, nb);
    end

    // Asynchronous reset in the middle of the data phase.
    i_enable = 1; i_mode = 2; i_crresp = 5'b00011; i_region_en = 0; i_acsnoop_flt_en = 0;
    i_delay = 0; i_delay_sel = 0;
    ace.cdready = 0; ace.crready = 1; ace.acvalid = 1; ace.acaddr = 44'h7000;
    n = 0;
    while (!ace.cdvalid && n < 50) begin
      @(negedge ace_aclk); n++;
      ace.acvalid = 1'b0;
    end
    check("t6_reach_cd", ace.cdvalid, 1);
    #2 ace_aresetn = 0;
    #1;
    check("t6_async_valids", {ace.crvalid, ace.cdvalid, ace.cdlast}, 0);
    check("t6_async_data", {ace.crresp, ace.cddata}, 0);
    check("t6_async_status", {o_done, o_hit_count, o_region_hit}, 0);
    m_done = 0; m_shots = 0; m_hits = 0;
    ace.cdready = 1;
    repeat (2) @(negedge ace_aclk);
    ace_aresetn = 1;
    @(negedge ace_aclk);
    check("t6_acready", ace.acready, 1);
    run_snoop(44'h7040, 4'h1, 0, 0, tcr, tfirst, tgap, rsp, nb); check("t6_after_rsp", rsp, 5'b00011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
